// File: rtl/irrigation_pkg.sv
// ---------------------------------------------------------------------------
// irrigation_pkg
//   Shared definitions for the irrigation window timer:
//     - state_t      : controller state (IDLE, COUNT, EXPIRED)
//     - BCD_W        : width of one BCD digit
//     - digit_max(i) : highest legal value of digit i
//                      (5 for the tens-of-seconds digit, 9 otherwise)
// ---------------------------------------------------------------------------
package irrigation_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // Digit 1 is tens of seconds and only runs 0..5; every other digit is
  // a plain decimal digit.
  function automatic logic [BCD_W-1:0] digit_max(input int i);
    return (i == 1) ? 4'd5 : 4'd9;
  endfunction

endpackage

// File: rtl/irrigation_timer_bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
//   One up/down BCD digit with a parallel load, chained to its neighbours
//   through a ripple enable.
//   Ports:
//     clk, clear_n : clock and asynchronous active-low reset
//     en           : step this digit on the next edge
//     dir          : 0 = increment, 1 = decrement
//     ld, ld_val   : parallel load (takes priority over en)
//     q            : current digit value
//     cout         : carry (up) / borrow (down) into the next digit
// ---------------------------------------------------------------------------
module bcd_digit
  import irrigation_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = 4'd9
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic             dir,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] q,
  output logic             cout
);

  // The next digit moves only when this one is stepping and is about to
  // wrap: at MAX when counting up, at zero when counting down.
  assign cout = en & (dir ? (q == '0) : (q == MAX));

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      if (dir) begin
        q <= (q == '0) ? MAX : q - 1'b1;
      end else begin
        q <= (q == MAX) ? '0 : q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/irrigation_timer.sv
// ---------------------------------------------------------------------------
// irrigation_timer
//   Cascadable BCD up/down time counter used to time irrigation windows.
//   Digit 0 = seconds units, digit 1 = seconds tens (0..5), digits 2.. are
//   decimal (minutes units, minutes tens, ...).
//   Parameters:
//     NDIG        : number of BCD digits (2..8)
//     AUTO_RELOAD : 1 = on down-count expiry reload the shadow value and
//                   keep counting
//   Ports:
//     clk, clear_n : clock and asynchronous active-low reset
//     tick         : one-cycle count enable, once per second
//     load         : load sanitised load_val into counter and shadow
//     load_val     : BCD preset, digit i at bits [4i+3:4i]
//     start, stop  : resume / pause counting (stop wins)
//     dir          : 0 = count up, 1 = count down
//     bcd_out      : current count, same packing as load_val
//     running      : high while in COUNT
//     done         : one-cycle pulse when a down count reaches zero
//     wrap         : one-cycle pulse when an up count rolls over to zero
// ---------------------------------------------------------------------------
module irrigation_timer
  import irrigation_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  tick,
  input  logic                  load,
  input  logic [BCD_W*NDIG-1:0] load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  output logic [BCD_W*NDIG-1:0] bcd_out,
  output logic                  running,
  output logic                  done,
  output logic                  wrap
);

  localparam int  W         = BCD_W * NDIG;
  localparam bit  RELOAD_EN = (AUTO_RELOAD != 0);

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   count;
  logic [W-1:0]   shadow;
  logic [W-1:0]   sanitised;
  logic [W-1:0]   dig_ld_val;
  logic           dig_ld;
  logic           shadow_ld;
  logic           step_en;
  logic           done_next;
  logic           wrap_next;
  logic [NDIG-1:0] dig_en;
  logic [NDIG-1:0] carry;
  logic           count_zero;
  logic           count_one;
  logic           shadow_zero;

  assign bcd_out     = count;
  assign count_zero  = (count == '0);
  assign count_one   = (count == W'(1));
  assign shadow_zero = (shadow == '0);

  // Clamp every preset digit to its legal range so the counter can never
  // hold a non-BCD value or a tens-of-seconds digit above 5.
  always_comb begin
    sanitised = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (load_val[BCD_W*i +: BCD_W] > digit_max(i)) begin
        sanitised[BCD_W*i +: BCD_W] = digit_max(i);
      end else begin
        sanitised[BCD_W*i +: BCD_W] = load_val[BCD_W*i +: BCD_W];
      end
    end
  end

  // Ripple enable: digit 0 steps on a counting tick, each higher digit
  // steps when the digit below it carries or borrows.
  assign dig_en[0] = step_en;
  for (genvar g = 1; g < NDIG; g++) begin : g_chain
    assign dig_en[g] = carry[g-1];
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit #(
      .MAX (digit_max(g))
    ) u_digit (
      .clk     (clk),
      .clear_n (clear_n),
      .en      (dig_en[g]),
      .dir     (dir),
      .ld      (dig_ld),
      .ld_val  (dig_ld_val[BCD_W*g +: BCD_W]),
      .q       (count[BCD_W*g +: BCD_W]),
      .cout    (carry[g])
    );
  end

  // An up step that carries out of the top digit was at all-max and is
  // rolling over to zero. Kept outside the FSM block so the carry chain
  // does not feed back into the process that drives step_en.
  assign wrap_next = step_en & ~dir & carry[NDIG-1];

  // Next-state and datapath control. Inputs are taken in strict priority
  // load > stop > start > tick, and only the winning one acts this cycle.
  always_comb begin
    state_next = state;
    step_en    = 1'b0;
    dig_ld     = 1'b0;
    dig_ld_val = shadow;
    shadow_ld  = 1'b0;
    done_next  = 1'b0;

    if (load) begin
      dig_ld     = 1'b1;
      dig_ld_val = sanitised;
      shadow_ld  = 1'b1;
      state_next = IDLE;
    end else if (stop) begin
      if (state == COUNT) begin
        state_next = IDLE;
      end
    end else if (start) begin
      case (state)
        IDLE: begin
          // A down count starting at zero has nothing to time: report
          // expiry straight away instead of running.
          if (!dir || !count_zero) begin
            state_next = COUNT;
          end else begin
            done_next = 1'b1;
          end
        end
        EXPIRED: begin
          dig_ld = 1'b1;
          if (shadow_zero) begin
            done_next = 1'b1;
          end else begin
            state_next = COUNT;
          end
        end
        default: begin
        end
      endcase
    end else if (tick && (state == COUNT)) begin
      if (dir && count_zero && RELOAD_EN) begin
        // Auto-reload: the tick after expiry restores the window length.
        dig_ld = 1'b1;
      end else begin
        step_en = 1'b1;
        if (dir && count_one) begin
          done_next = 1'b1;
          if (!RELOAD_EN) begin
            state_next = EXPIRED;
          end
        end
      end
    end
  end

  // State, shadow and registered status outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state   <= IDLE;
      shadow  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == COUNT);
      done    <= done_next;
      wrap    <= wrap_next;
      if (shadow_ld) begin
        shadow <= sanitised;
      end
    end
  end

endmodule

// File: tb/tb_irrigation_timer.sv
// ---------------------------------------------------------------------------
// tb_irrigation_timer
//   Drives two timers (AUTO_RELOAD = 0 and 1) from the same inputs. Every
//   stimulus cycle pushes the hand-computed response of both into a queue;
//   a monitor pops one entry after each rising edge and compares.
//   Flags are packed {running, done, wrap}.
// ---------------------------------------------------------------------------
module tb_irrigation_timer;

  localparam int NDIG = 4;
  localparam logic [2:0] N  = 3'b000;
  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] RD = 3'b110;
  localparam logic [2:0] RW = 3'b101;
  localparam logic [2:0] D  = 3'b010;

  typedef struct {
    int          idx;
    logic [15:0] bcd;
    logic [2:0]  fl;
    logic [15:0] bcd_ar;
    logic [2:0]  fl_ar;
  } exp_t;

  logic        clk;
  logic        clear_n;
  logic        tick;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;
  logic        dir;
  logic [15:0] bcd_out;
  logic        running;
  logic        done;
  logic        wrap;
  logic [15:0] bcd_out_ar;
  logic        running_ar;
  logic        done_ar;
  logic        wrap_ar;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   vec_idx;

  irrigation_timer #(
    .NDIG        (NDIG),
    .AUTO_RELOAD (0)
  ) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .bcd_out  (bcd_out),
    .running  (running),
    .done     (done),
    .wrap     (wrap)
  );

  irrigation_timer #(
    .NDIG        (NDIG),
    .AUTO_RELOAD (1)
  ) dut_ar (
    .clk      (clk),
    .clear_n  (clear_n),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .dir      (dir),
    .bcd_out  (bcd_out_ar),
    .running  (running_ar),
    .done     (done_ar),
    .wrap     (wrap_ar)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares {bcd, running, done, wrap} and records the result.
  task automatic check_output(input string name, input int idx,
                              input logic [18:0] actual,
                              input logic [18:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got bcd=%h r/d/w=%b, expected bcd=%h r/d/w=%b",
               name, idx, actual[18:3], actual[2:0], expected[18:3], expected[2:0]);
    end
  endtask

  // Drives one cycle of inputs and queues the expected response of both
  // timers after the following rising edge.
  task automatic apply_stimulus(input logic ld, input logic [15:0] val,
                                input logic st, input logic sp,
                                input logic dr, input logic tk,
                                input logic [15:0] e_bcd, input logic [2:0] e_fl,
                                input logic [15:0] a_bcd, input logic [2:0] a_fl);
    exp_t e;
    @(negedge clk);
    load     = ld;
    load_val = val;
    start    = st;
    stop     = sp;
    dir      = dr;
    tick     = tk;
    vec_idx++;
    e.idx    = vec_idx;
    e.bcd    = e_bcd;
    e.fl     = e_fl;
    e.bcd_ar = a_bcd;
    e.fl_ar  = a_fl;
    exp_q.push_back(e);
  endtask

  // Monitor: one queued expectation per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("main", e.idx, {bcd_out, running, done, wrap},
                     {e.bcd, e.fl});
        check_output("reload", e.idx, {bcd_out_ar, running_ar, done_ar, wrap_ar},
                     {e.bcd_ar, e.fl_ar});
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    vec_idx  = 0;
    tick     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    start    = 1'b0;
    stop     = 1'b0;
    dir      = 1'b0;
    clear_n  = 1'b1;
    #1 clear_n = 1'b0;
    #1;
    check_output("reset_main", 0, {bcd_out, running, done, wrap}, {16'h0000, N});
    check_output("reset_reload", 0, {bcd_out_ar, running_ar, done_ar, wrap_ar}, {16'h0000, N});
    @(negedge clk);
    clear_n = 1'b1;

    //             ld  val      st sp dr tk   main          reload
    // Down count 00:03 to expiry; reload variant restarts from shadow.
    apply_stimulus(1, 16'h0003, 0, 0, 1, 0, 16'h0003, N,  16'h0003, N);
    apply_stimulus(0, 16'h0000, 1, 0, 1, 0, 16'h0003, R,  16'h0003, R);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0002, R,  16'h0002, R);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0001, R,  16'h0001, R);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0000, D,  16'h0000, RD);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0000, N,  16'h0003, R);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0000, N,  16'h0002, R);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 0, 16'h0000, N,  16'h0002, R);
    // Start from EXPIRED restores the shadow value.
    apply_stimulus(0, 16'h0000, 1, 0, 1, 0, 16'h0003, R,  16'h0002, R);
    apply_stimulus(0, 16'h0000, 0, 1, 1, 0, 16'h0003, N,  16'h0002, N);

    // 01:00 down one tick: borrow through the mod-6 digit.
    apply_stimulus(1, 16'h0100, 0, 0, 1, 0, 16'h0100, N,  16'h0100, N);
    apply_stimulus(0, 16'h0000, 1, 0, 1, 0, 16'h0100, R,  16'h0100, R);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0059, R,  16'h0059, R);
    apply_stimulus(0, 16'h0000, 0, 1, 1, 0, 16'h0059, N,  16'h0059, N);

    // Up count from 99:58 through the all-max rollover, then reverse.
    apply_stimulus(1, 16'h9958, 0, 0, 0, 0, 16'h9958, N,  16'h9958, N);
    apply_stimulus(0, 16'h0000, 1, 0, 0, 0, 16'h9958, R,  16'h9958, R);
    apply_stimulus(0, 16'h0000, 0, 0, 0, 1, 16'h9959, R,  16'h9959, R);
    apply_stimulus(0, 16'h0000, 0, 0, 0, 1, 16'h0000, RW, 16'h0000, RW);
    apply_stimulus(0, 16'h0000, 0, 0, 0, 1, 16'h0001, R,  16'h0001, R);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0000, D,  16'h0000, RD);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0000, N,  16'h9958, R);
    apply_stimulus(0, 16'h0000, 0, 1, 1, 0, 16'h0000, N,  16'h9958, N);

    // Sanitised preset with start and tick in the same cycle: load only.
    apply_stimulus(1, 16'h0A7F, 1, 0, 1, 1, 16'h0959, N,  16'h0959, N);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0959, N,  16'h0959, N);

    // Down start at zero: stays IDLE, done pulses once.
    apply_stimulus(1, 16'h0000, 0, 0, 1, 0, 16'h0000, N,  16'h0000, N);
    apply_stimulus(0, 16'h0000, 1, 0, 1, 0, 16'h0000, D,  16'h0000, D);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 0, 16'h0000, N,  16'h0000, N);

    // Stop and start together at 00:05: stop wins, ticks ignored.
    apply_stimulus(1, 16'h0005, 0, 0, 1, 0, 16'h0005, N,  16'h0005, N);
    apply_stimulus(0, 16'h0000, 1, 0, 1, 0, 16'h0005, R,  16'h0005, R);
    apply_stimulus(0, 16'h0000, 1, 1, 1, 0, 16'h0005, N,  16'h0005, N);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0005, N,  16'h0005, N);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0005, N,  16'h0005, N);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0005, N,  16'h0005, N);
    apply_stimulus(0, 16'h0000, 1, 0, 1, 0, 16'h0005, R,  16'h0005, R);
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0004, R,  16'h0004, R);
    apply_stimulus(0, 16'h0000, 0, 1, 1, 1, 16'h0004, N,  16'h0004, N);
    apply_stimulus(0, 16'h0000, 1, 0, 1, 0, 16'h0004, R,  16'h0004, R);

    // Asynchronous clear between edges while running.
    @(posedge clk);
    #3;
    start   = 1'b0;
    clear_n = 1'b0;
    #1;
    check_output("async_clear_main", vec_idx, {bcd_out, running, done, wrap}, {16'h0000, N});
    check_output("async_clear_reload", vec_idx,
                 {bcd_out_ar, running_ar, done_ar, wrap_ar}, {16'h0000, N});
    @(negedge clk);
    clear_n = 1'b1;
    apply_stimulus(0, 16'h0000, 0, 0, 1, 1, 16'h0000, N,  16'h0000, N);

    @(negedge clk);
    tick = 1'b0;
    dir  = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
